// File: rtl/obstacle_collision_detector_pkg.sv
// obstacle_pkg: edge bit positions, detector state and edge-code types shared by the collision detector.
package obstacle_pkg;
  localparam int EDGE_LEFT = 3;
  localparam int EDGE_TOP = 2;
  localparam int EDGE_RIGHT = 1;
  localparam int EDGE_BOTTOM = 0;
  typedef enum logic {ARMED, COOLDOWN} hit_state_t;
  typedef logic [3:0] edge_code_t;
endpackage

// File: rtl/obstacle_collision_detector_if.sv
// obstacle_collision_detector_if: per-pixel draw requests in, per-frame collision pulses out.
interface obstacle_collision_detector_if;
  import obstacle_pkg::*;
  logic startOfFrame;
  logic obstacle_DR;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic step_DR;
  logic missile_DR;
  logic collision;
  edge_code_t HitEdgeCode;
  logic SHP_shootObstacle;
  modport master (
    output startOfFrame, obstacle_DR, offsetX, offsetY, step_DR, missile_DR,
    input collision, HitEdgeCode, SHP_shootObstacle
  );
  modport slave (
    input startOfFrame, obstacle_DR, offsetX, offsetY, step_DR, missile_DR,
    output collision, HitEdgeCode, SHP_shootObstacle
  );
endinterface

// File: rtl/obstacle_collision_detector_classifier.sv
// hit_edge_classifier: maps an in-object pixel offset to the {Left, Top, Right, Bottom} edge bits.
module hit_edge_classifier
  import obstacle_pkg::*;
#(
  parameter int OBJ_WIDTH = 64,
  parameter int OBJ_HEIGHT = 8,
  parameter int EDGE_MARGIN = 4
) (
  input  logic [10:0] offset_x,
  input  logic [10:0] offset_y,
  output edge_code_t  edge_bits
);
  localparam logic [10:0] MARGIN = 11'(EDGE_MARGIN);
  localparam logic [10:0] RIGHT_TH = 11'(OBJ_WIDTH - EDGE_MARGIN);
  localparam logic [10:0] BOTTOM_TH = 11'(OBJ_HEIGHT - EDGE_MARGIN);
  always_comb begin
    edge_bits = '0;
    edge_bits[EDGE_LEFT] = offset_x < MARGIN;
    edge_bits[EDGE_TOP] = offset_y < MARGIN;
    edge_bits[EDGE_RIGHT] = offset_x >= RIGHT_TH;
    edge_bits[EDGE_BOTTOM] = offset_y >= BOTTOM_TH;
  end
endmodule

// File: rtl/obstacle_collision_detector.sv
// obstacle_collision_detector: per-frame step/missile collision pulses with hit-edge code.
// Define OBSTACLE_HIT_COOLDOWN_EN to suppress collision for COOLDOWN_FRAMES boundaries after each report.
module obstacle_collision_detector
  import obstacle_pkg::*;
#(
  parameter int OBJ_WIDTH = 64,
  parameter int OBJ_HEIGHT = 8,
  parameter int EDGE_MARGIN = 4,
  parameter int COOLDOWN_FRAMES = 3
) (
  input logic clk,
  input logic resetN,
  obstacle_collision_detector_if.slave bus
);
  edge_code_t edge_bits, hit_bits, edge_acc, code_r;
  logic sof, hit, shot, hit_seen, shot_seen, armed, collision_r, shoot_r;
  hit_edge_classifier #(
    .OBJ_WIDTH(OBJ_WIDTH),
    .OBJ_HEIGHT(OBJ_HEIGHT),
    .EDGE_MARGIN(EDGE_MARGIN)
  ) u_classifier (
    .offset_x(bus.offsetX),
    .offset_y(bus.offsetY),
    .edge_bits(edge_bits)
  );
  assign sof = bus.startOfFrame;
  assign hit = bus.obstacle_DR & bus.step_DR;
  assign shot = bus.obstacle_DR & bus.missile_DR;
  assign hit_bits = hit ? edge_bits : '0;
  // a pixel coinciding with startOfFrame seeds the new frame's accumulators
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      hit_seen <= 1'b0;
      shot_seen <= 1'b0;
      edge_acc <= '0;
    end else begin
      hit_seen <= hit | (hit_seen & ~sof);
      shot_seen <= shot | (shot_seen & ~sof);
      edge_acc <= hit_bits | (sof ? '0 : edge_acc);
    end
`ifdef OBSTACLE_HIT_COOLDOWN_EN
  hit_state_t state;
  logic [3:0] cnt;
  assign armed = state == ARMED;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= ARMED;
      cnt <= '0;
    end else if (sof) begin
      if (state == ARMED) begin
        if (hit_seen) begin
          state <= COOLDOWN;
          cnt <= 4'(COOLDOWN_FRAMES);
        end
      end else begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= ARMED;
      end
    end
`else
  assign armed = 1'b1;
`endif
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      collision_r <= 1'b0;
      shoot_r <= 1'b0;
      code_r <= '0;
    end else begin
      collision_r <= sof & hit_seen & armed;
      shoot_r <= sof & shot_seen;
      if (sof & hit_seen & armed) code_r <= edge_acc;
    end
  assign bus.collision = collision_r;
  assign bus.SHP_shootObstacle = shoot_r;
  assign bus.HitEdgeCode = code_r;
endmodule

// File: tb/tb_obstacle_collision_detector.sv
// tb_obstacle_collision_detector: directed frames; expected boundary responses queued, checked by a monitor.
module tb_obstacle_collision_detector;
  import obstacle_pkg::*;
  typedef struct {
    logic col;
    logic sh;
    edge_code_t code;
    int id;
  } exp_t;
`ifdef OBSTACLE_HIT_COOLDOWN_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif
  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sof_q = 1'b0;
  int total = 0;
  int bad = 0;
  int nb = 0;
  exp_t exp_q[$];
  exp_t e;
  always #5 clk = ~clk;
  obstacle_collision_detector_if bus ();
  obstacle_collision_detector #(
    .OBJ_WIDTH(64),
    .OBJ_HEIGHT(8),
    .EDGE_MARGIN(3),
    .COOLDOWN_FRAMES(3)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus)
  );
  always @(posedge clk) sof_q <= bus.startOfFrame;
  // every cycle after a boundary pops one expectation; any other cycle must be pulse-free
  always @(negedge clk)
    if (resetN === 1'b1) begin
      if (sof_q) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL boundary_unexpected: got col=%b shoot=%b code=%b", bus.collision, bus.SHP_shootObstacle, bus.HitEdgeCode);
        end else begin
          e = exp_q.pop_front();
          if ({bus.collision, bus.SHP_shootObstacle, bus.HitEdgeCode} !== {e.col, e.sh, e.code}) begin
            bad++;
            $display("FAIL boundary%0d: got col=%b shoot=%b code=%b want col=%b shoot=%b code=%b", e.id, bus.collision, bus.SHP_shootObstacle, bus.HitEdgeCode, e.col, e.sh, e.code);
          end
        end
      end else begin
        total++;
        if (bus.collision !== 1'b0 || bus.SHP_shootObstacle !== 1'b0) begin
          bad++;
          $display("FAIL stray_pulse at %0t: got col=%b shoot=%b want 0 0", $time, bus.collision, bus.SHP_shootObstacle);
        end
      end
    end
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
  endtask
  task automatic cyc(input logic s, input logic ob, input logic [10:0] x, input logic [10:0] y, input logic st, input logic mi);
    bus.startOfFrame = s;
    bus.obstacle_DR = ob;
    bus.offsetX = x;
    bus.offsetY = y;
    bus.step_DR = st;
    bus.missile_DR = mi;
    @(posedge clk);
    #1;
    bus.startOfFrame = 1'b0;
    bus.obstacle_DR = 1'b0;
    bus.step_DR = 1'b0;
    bus.missile_DR = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0);
  endtask
  task automatic hitpix(input logic [10:0] x, input logic [10:0] y);
    cyc(1'b0, 1'b1, x, y, 1'b1, 1'b0);
  endtask
  task automatic expect_b(input logic c, input logic sh, input edge_code_t code);
    exp_q.push_back('{c, sh, code, nb});
    nb++;
  endtask
  task automatic boundary(input logic c, input logic sh, input edge_code_t code);
    expect_b(c, sh, code);
    cyc(1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    idle(1);
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bus.startOfFrame = 1'b0;
    bus.obstacle_DR = 1'b0;
    bus.offsetX = '0;
    bus.offsetY = '0;
    bus.step_DR = 1'b0;
    bus.missile_DR = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_collision", {3'b0, bus.collision}, 4'b0);
    chk("reset_shoot", {3'b0, bus.SHP_shootObstacle}, 4'b0);
    chk("reset_code", bus.HitEdgeCode, 4'b0);
    @(posedge clk);
    #1 resetN = 1'b1;
    // left-edge hit; non-step obstacle pixel and obstacle-less step/missile ignored
    boundary(0, 0, 4'b0000);
    hitpix(11'd0, 11'd3);
    cyc(1'b0, 1'b1, 11'd0, 11'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 11'd63, 11'd7, 1'b1, 1'b1);
    boundary(1, 0, 4'b1000);
    idle(3);
    boundary(0, 0, 4'b1000);
    // two right-side corners in one frame
    do_reset();
    boundary(0, 0, 4'b0000);
    hitpix(11'd63, 11'd0);
    idle(2);
    hitpix(11'd63, 11'd7);
    boundary(1, 0, 4'b0111);
    idle(2);
    // out-of-range offsets, then interior-only hit reports code 0
    do_reset();
    boundary(0, 0, 4'b0000);
    hitpix(11'd100, 11'd20);
    boundary(1, 0, 4'b0011);
    repeat (3) begin
      idle(1);
      boundary(0, 0, 4'b0011);
    end
    hitpix(11'd30, 11'd4);
    boundary(1, 0, 4'b0000);
    // hit in every frame: cooldown pattern
    do_reset();
    boundary(0, 0, 4'b0000);
    hitpix(11'd0, 11'd4);
    for (int k = 1; k <= 9; k++) begin
      boundary(CD ? (k == 1 || k == 5 || k == 9) : 1'b1, 0, 4'b1000);
      hitpix(11'd0, 11'd4);
    end
    // missile during cooldown still fires
    do_reset();
    boundary(0, 0, 4'b0000);
    hitpix(11'd0, 11'd4);
    boundary(1, 0, 4'b1000);
    cyc(1'b0, 1'b1, 11'd20, 11'd4, 1'b1, 1'b1);
    boundary(!CD, 1, CD ? 4'b1000 : 4'b0000);
    cyc(1'b0, 1'b1, 11'd20, 11'd4, 1'b0, 1'b1);
    boundary(0, 1, CD ? 4'b1000 : 4'b0000);
    // hit coinciding with startOfFrame belongs to the new frame; back-to-back boundaries
    do_reset();
    boundary(0, 0, 4'b0000);
    idle(2);
    expect_b(0, 0, 4'b0000);
    cyc(1'b1, 1'b1, 11'd0, 11'd4, 1'b1, 1'b1);
    idle(2);
    boundary(1, 1, 4'b1000);
    boundary(0, 0, 4'b1000);
    boundary(0, 0, 4'b1000);
    // asynchronous reset mid-frame after a hit
    do_reset();
    boundary(0, 0, 4'b0000);
    hitpix(11'd0, 11'd4);
    boundary(1, 0, 4'b1000);
    hitpix(11'd63, 11'd4);
    #3 resetN = 1'b0;
    #1 chk("async_reset_code", bus.HitEdgeCode, 4'b0000);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    boundary(0, 0, 4'b0000);
    hitpix(11'd0, 11'd4);
    boundary(1, 0, 4'b1000);
    idle(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expectations: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/obstacle_collision_detector.md
# obstacle_collision_detector

Per-frame collision detector that sits directly upstream of the bouncing-obstacle trajectory logic. Over each video frame it watches coincident draw requests: obstacle with step/border, and obstacle with missile. At the next frame boundary it issues single-cycle `collision` and `SHP_shootObstacle` pulses, together with a registered 4-bit hit-edge code. A frame-count cooldown keeps one physical contact from flipping the obstacle's speed on consecutive frames.

## Interface
Parameters:
- `OBJ_WIDTH`, 64: obstacle bitmap width in pixels.
- `OBJ_HEIGHT`, 8: obstacle bitmap height in pixels.
- `EDGE_MARGIN`, 4: pixel band, measured inward from each side, that classifies a hit as that edge.
- `COOLDOWN_FRAMES`, 3: frames collision is suppressed after a reported collision (1..15).

Ports:
- `clk`, in, 1: pixel clock.
- `resetN`, in, 1: asynchronous, active-low reset.
- `startOfFrame`, in, 1: one-cycle pulse at the start of every frame.
- `obstacle_DR`, in, 1: obstacle is drawing the current pixel.
- `offsetX`, in, 11: unsigned pixel offset inside the obstacle; valid when `obstacle_DR`=1.
- `offsetY`, in, 11: unsigned pixel offset inside the obstacle; valid when `obstacle_DR`=1.
- `step_DR`, in, 1: step or border is drawing the current pixel.
- `missile_DR`, in, 1: missile is drawing the current pixel.
- `collision`, out, 1: one-cycle pulse; obstacle touched a step or border in the previous frame.
- `HitEdgeCode`, out, 4: {Left, Top, Right, Bottom} edges touched; valid with `collision` and held until the next update.
- `SHP_shootObstacle`, out, 1: one-cycle pulse; missile overlapped the obstacle in the previous frame.

## Operation
- Edge classification is combinational and applies when `obstacle_DR`:
  - bit3 (Left): `offsetX < EDGE_MARGIN`
  - bit1 (Right): `offsetX >= OBJ_WIDTH-EDGE_MARGIN`
  - bit2 (Top): `offsetY < EDGE_MARGIN`
  - bit0 (Bottom): `offsetY >= OBJ_HEIGHT-EDGE_MARGIN`
  - In a corner, two bits are set.
- Step hit: on any cycle with `obstacle_DR && step_DR`, set `hit_seen` and OR the classified bits into `edge_acc`.
- Missile hit: on any cycle with `obstacle_DR && missile_DR`, set `shot_seen`.
- States:
  - ARMED to COOLDOWN: at `startOfFrame` with `hit_seen`=1. Pulse `collision`, load `HitEdgeCode`<=`edge_acc`, load cnt<=`COOLDOWN_FRAMES`.
  - ARMED to ARMED: at `startOfFrame` with `hit_seen`=0. No pulse, `HitEdgeCode` unchanged.
  - COOLDOWN: at each `startOfFrame`, decrement cnt, discard `hit_seen`. When cnt reaches 1, return to ARMED, so exactly `COOLDOWN_FRAMES` boundaries are suppressed.
- `SHP_shootObstacle` fires at `startOfFrame` whenever `shot_seen`=1, in any state. The cooldown does not apply to it.
- A hit whose `edge_acc` is 0 (interior pixel only) is still reported: `collision` pulses with `HitEdgeCode`=0.
- `startOfFrame` closes the frame: `hit_seen`, `shot_seen` and `edge_acc` are cleared.
- Simultaneous `startOfFrame` and a hit pixel: that pixel belongs to the new frame. Accumulators load with that pixel's contribution rather than clearing to 0.
- All comparisons are unsigned 11-bit. Offsets at or beyond `OBJ_WIDTH`/`OBJ_HEIGHT` still classify as Right/Bottom.

## Timing
- Reset values: `collision`=0, `SHP_shootObstacle`=0, `HitEdgeCode`=0, state ARMED, cnt=0, all accumulators 0.
- Latency: a hit pixel in frame N produces its pulse in the cycle after the `startOfFrame` that opens frame N+1.
- Both output pulses are registered and exactly one cycle wide.
- `HitEdgeCode` updates on the same edge as the `collision` rise.
- Reset mid-frame: everything returns to reset values. The partial frame after release accumulates normally.
- Back-to-back `startOfFrame` pulses are each treated as a frame boundary.

## Configuration
- `OBSTACLE_HIT_COOLDOWN_EN` defined: COOLDOWN state and cnt exist as described above.
- Not defined: the FSM is always ARMED and every frame containing a step hit pulses `collision`. cnt logic is not synthesized.

## Structure
- Shared package `obstacle_pkg` holds:
  - edge bit indices `EDGE_LEFT`=3, `EDGE_TOP`=2, `EDGE_RIGHT`=1, `EDGE_BOTTOM`=0;
  - enum `hit_state_t` {ARMED, COOLDOWN};
  - typedef `edge_code_t` (logic [3:0]).
- Sub-module `hit_edge_classifier`: combinational offset-to-edge-bits mapping, parameterized by `OBJ_WIDTH`, `OBJ_HEIGHT`, `EDGE_MARGIN`.

## Test plan
- Step hit at offset (0,3) in frame 1: at the next `startOfFrame`, `collision` pulses for 1 cycle with `HitEdgeCode`=4'b1000.
- Hits at (63,0) and (63,7) in one frame: `HitEdgeCode`=4'b0111, single pulse.
- Step hit every frame with the macro on and `COOLDOWN_FRAMES`=3: pulses on boundaries 1, 5, 9. With the macro off: a pulse on every boundary.
- Missile overlap during COOLDOWN: `SHP_shootObstacle` pulses for 1 cycle at the next boundary and `collision` stays 0.
- Hit pixel coinciding with `startOfFrame`: no pulse at that boundary, pulse at the following one.
- `resetN` asserted mid-frame after a hit: no pulse at the next boundary and `HitEdgeCode`=0.
